// File: rtl/lcd_bus_responder_pkg.sv
// Shared constants, FSM states and command decode for the LCD bus responder.
package lcd_bus_responder_pkg;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;
    localparam int SHADOW_DEPTH = 32;

    localparam int CMD_DDRAM_BIT = 7;
    localparam int CMD_CGRAM_BIT = 6;
    localparam int CMD_FUNC_BIT  = 5;
    localparam int CMD_SHIFT_BIT = 4;
    localparam int CMD_DISP_BIT  = 3;
    localparam int CMD_ENTRY_BIT = 2;
    localparam int CMD_HOME_BIT  = 1;
    localparam int CMD_CLEAR_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BUSY
    } state_t;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_t;

    // The highest set bit selects the instruction.
    function automatic cmd_t decodeCmd(input logic [7:0] d);
        if (d[CMD_DDRAM_BIT]) return CMD_DDRAM;
        if (d[CMD_CGRAM_BIT]) return CMD_CGRAM;
        if (d[CMD_FUNC_BIT])  return CMD_FUNC;
        if (d[CMD_SHIFT_BIT]) return CMD_SHIFT;
        if (d[CMD_DISP_BIT])  return CMD_DISP;
        if (d[CMD_ENTRY_BIT]) return CMD_ENTRY;
        if (d[CMD_HOME_BIT])  return CMD_HOME;
        if (d[CMD_CLEAR_BIT]) return CMD_CLEAR;
        return CMD_NOP;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_addr_step.sv
// Two-line DDRAM address stepping and shadow index mapping.
module lcd_addr_step
    import lcd_bus_responder_pkg::*;
(
    input  logic [6:0] cursorAddr,
    input  logic       entryIncrement,
    output logic [6:0] nextAddr,
    output logic [4:0] shadowIdx,
    output logic       shadowValid
);

    always_comb begin
        nextAddr = cursorAddr;
        if (entryIncrement) begin
            if (cursorAddr == LINE1_LAST)
                nextAddr = LINE2_BASE;
            else if (cursorAddr == LINE2_LAST)
                nextAddr = LINE1_BASE;
            else
                nextAddr = cursorAddr + 7'd1;
        end else begin
            if (cursorAddr == LINE1_BASE)
                nextAddr = LINE2_LAST;
            else if (cursorAddr == LINE2_BASE)
                nextAddr = LINE1_LAST;
            else
                nextAddr = cursorAddr - 7'd1;
        end
    end

    // Only the first 16 columns of each line are shadowed.
    assign shadowValid = (cursorAddr[6:4] == 3'b000)
                       || (cursorAddr[6:4] == 3'b100);
    assign shadowIdx = {cursorAddr[6], cursorAddr[3:0]};

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder with 2x16 shadow RAM and busy emulation.
// Define LCD_RESPONDER_ERR_EN to track writes strobed while busy.
module lcd_bus_responder
    import lcd_bus_responder_pkg::*;
#(
    parameter int BUSY_CYCLES       = 2000,
    parameter int CLEAR_BUSY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       lcdOn,
    input  logic       lcdRs,
    input  logic       lcdEn,
    input  logic       lcdRw,
    input  logic [7:0] lcdData,
    input  logic [4:0] rdAddr,
    output logic [7:0] rdChar,
    output logic [6:0] cursorAddr,
    output logic       displayOn,
    output logic       entryIncrement,
    output logic       busy,
    output logic       protocolError
);

    localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_BUSY_CYCLES)
                              ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             regOn;
    logic             regRs;
    logic             regEn;
    logic             regRw;
    logic [7:0]       regData;
    logic             prevEn;
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [4:0]       fillIdx;
    logic [7:0]       shadow [SHADOW_DEPTH];

    logic       strobe;
    logic       wr;
    cmd_t       cmd;
    logic [6:0] nextAddr;
    logic [4:0] shadowIdx;
    logic       shadowValid;

    assign strobe = prevEn & ~regEn & regOn;
    assign wr     = strobe & ~regRw;
    assign cmd    = decodeCmd(regData);
    assign busy   = (state != S_IDLE);

    lcd_addr_step addrStep (
        .cursorAddr    (cursorAddr),
        .entryIncrement(entryIncrement),
        .nextAddr      (nextAddr),
        .shadowIdx     (shadowIdx),
        .shadowValid   (shadowValid)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            regOn          <= 1'b0;
            regRs          <= 1'b0;
            regEn          <= 1'b0;
            regRw          <= 1'b0;
            regData        <= 8'h00;
            prevEn         <= 1'b0;
            state          <= S_IDLE;
            count          <= '0;
            fillIdx        <= '0;
            cursorAddr     <= LINE1_BASE;
            displayOn      <= 1'b0;
            entryIncrement <= 1'b1;
            rdChar         <= SPACE_CHAR;
            for (int i = 0; i < SHADOW_DEPTH; i++)
                shadow[i] <= SPACE_CHAR;
        end else begin
            regOn   <= lcdOn;
            regRs   <= lcdRs;
            regEn   <= lcdEn;
            regRw   <= lcdRw;
            regData <= lcdData;
            prevEn  <= regEn;
            rdChar  <= shadow[rdAddr];

            unique case (state)
                S_IDLE: begin
                    unique case (1'b1)
                        (wr && regRs): begin
                            if (shadowValid)
                                shadow[shadowIdx] <= regData;
                            cursorAddr <= nextAddr;
                            state      <= S_BUSY;
                            count      <= BUSY_LOAD;
                        end
                        (wr && !regRs): begin
                            unique case (cmd)
                                CMD_DDRAM: cursorAddr     <= regData[6:0];
                                CMD_DISP:  displayOn      <= regData[2];
                                CMD_ENTRY: entryIncrement <= regData[1];
                                CMD_HOME:  cursorAddr     <= LINE1_BASE;
                                CMD_CLEAR: begin
                                    cursorAddr     <= LINE1_BASE;
                                    entryIncrement <= 1'b1;
                                end
                                default: ;
                            endcase
                            if (cmd == CMD_CLEAR) begin
                                fillIdx <= '0;
                                state   <= S_FILL;
                            end else if (cmd != CMD_NOP) begin
                                state <= S_BUSY;
                                count <= (cmd == CMD_HOME) ? CLEAR_LOAD
                                                           : BUSY_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
                S_FILL: begin
                    shadow[fillIdx] <= SPACE_CHAR;
                    fillIdx         <= fillIdx + 5'd1;
                    if (fillIdx == 5'd31) begin
                        state <= S_BUSY;
                        count <= CLEAR_LOAD;
                    end
                end
                S_BUSY: begin
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LCD_RESPONDER_ERR_EN
    logic errSticky;

    always_ff @(posedge clk) begin
        if (!resetN)
            errSticky <= 1'b0;
        else if (wr && busy)
            errSticky <= 1'b1;
    end

    assign protocolError = errSticky;
`else
    assign protocolError = 1'b0;
`endif

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Receiving end of the HD44780-style character-LCD bus driven by the team's LCD writer. Samples LCD_ON/RS/EN/RW/DATA, decodes commands and character writes on each EN falling edge, and keeps a 2x16 shadow of display RAM, cursor address and display mode. Emulates the controller's busy time and flags writes that violate it. Used as an on-chip checker and bench target for the LCD path of the prescription reminder.

## Interface
- BUSY_CYCLES, 2000: busy duration after a normal command or data write (40 us at 50 MHz).
- CLEAR_BUSY_CYCLES, 82000: busy duration after clear-display or return-home (1.64 ms).
- clk  in  1  system clock, 50 MHz.
- resetN  in  1  one clock; reset is synchronous and active-low.
- lcdOn  in  1  LCD power/enable line; bus ignored while 0.
- lcdRs  in  1  register select: 0 command, 1 data.
- lcdEn  in  1  strobe; transfer taken on falling edge.
- lcdRw  in  1  0 write, 1 read.
- lcdData  in  8  bus data.
- rdAddr  in  5  shadow index: 0-15 line 1, 16-31 line 2.
- rdChar  out  8  shadow character at rdAddr, registered.
- cursorAddr  out  7  current DDRAM address counter.
- displayOn  out  1  display-on bit from display control.
- entryIncrement  out  1  1 increment, 0 decrement.
- busy  out  1  emulated busy flag.
- protocolError  out  1  sticky; write strobed while busy.

## Operation
- All bus inputs registered once (regEn etc.), plus prevEn. Strobe = prevEn & ~regEn & lcdOn-registered.
- Strobe with regRw=1: ignored (no effect, no error).
- Strobe with regRw=0 while busy: ignored; protocolError set.
- Strobe with regRw=0, RS=1 (data): if cursorAddr in 0x00-0x0F store to index addr, in 0x40-0x4F to index 16+(addr-0x40), else discard; then step cursorAddr; busy BUSY_CYCLES.
- Command decode by highest set bit of data: bit7 set DDRAM address = data[6:0]; bit6 CGRAM addr (no state change); bit5 function set (no state change); bit4 cursor/display shift (no state change); bit3 displayOn=data[2]; bit2 entryIncrement=data[1]; bit1 return home: cursorAddr=0, busy CLEAR_BUSY_CYCLES; bit0 clear: fill all 32 entries with 0x20, cursorAddr=0, entryIncrement=1, then busy CLEAR_BUSY_CYCLES; data 0x00 no-op, no busy. All other commands busy BUSY_CYCLES.
- Address step (2-line map): increment 0x27->0x40, 0x67->0x00, else +1; decrement 0x00->0x67, 0x40->0x27, else -1. Set-address values outside both windows accepted as-is.
- FSM: IDLE -> BUSY (count loaded) on accepted strobe; IDLE -> FILL on clear; FILL writes one entry per cycle, index 0..31, then -> BUSY; BUSY counts down, -> IDLE at count 1. busy = (state != IDLE).
- Reset: state IDLE, all entries 0x20, cursorAddr 0, entryIncrement 1, displayOn 0, protocolError 0, rdChar 0x20. Reset mid-FILL or mid-BUSY aborts immediately.

## Timing
- Pin EN falling sampled at edge N; strobe valid in cycle after N; state/outputs updated at edge N+1.
- busy high from edge N+1 for exactly BUSY_CYCLES cycles (clear: 32 FILL cycles + CLEAR_BUSY_CYCLES).
- rdChar: 1-cycle latency from rdAddr; reflects a same-cycle shadow write on the following cycle.
- Strobe on exactly the cycle busy falls: busy is registered, so that strobe is accepted.
- lcdOn low: no strobes accepted; outputs hold.

## Configuration
- LCD_RESPONDER_ERR_EN defined: protocolError tracked as above.
- Not defined: protocolError tied 0, no detection logic; writes during busy still ignored.

## Structure
- Shared package: command bit positions, space char 0x20, line base addresses 0x00/0x40, wrap limits 0x27/0x67, FSM state enum.
- One sub-module: lcd_addr_step (combinational next-address from cursorAddr and entryIncrement, plus shadow index/valid mapping).

## Test plan
- Reset, rdAddr 0..31 -> rdChar 0x20 everywhere, cursorAddr 0, busy 0, entryIncrement 1.
- Command 0x80, wait, data 0x41 -> shadow[0]=0x41, cursorAddr 0x01, busy exactly 2000 cycles.
- Set address 0x27, write 'A' (increment) -> cursorAddr 0x40, char discarded; next write lands at index 16.
- Entry mode 0x04, set 0x40, write -> cursorAddr 0x27; set 0x00, write -> cursorAddr 0x67.
- Fill line 1, command 0x01 -> busy 32+82000 cycles, all entries 0x20, cursorAddr 0.
- Data write 10 cycles after previous -> ignored, protocolError 1 (0 with LCD_RESPONDER_ERR_EN undefined); resetN low clears it.
